// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC, imem read handshake and IF/ID register.
// Ports: clk, rst; stall_id, redirect/redirect_pc from ID;
//   imem_rd/imem_addr out, imem_data/imem_done/imem_stall in;
//   instr_id/pc2_id/valid_id IF/ID outputs; halted when fetch is frozen.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_stall,
  output logic [15:0] instr_id,
  output logic [15:0] pc2_id,
  output logic        valid_id,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT, S_HOLD, S_DRAIN, S_HALT
  } state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
  } if_id_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] hold_q, hold_d;
  logic        halted_q, halted_d;
  if_id_t      ifid_q, ifid_d;
  if_id_t      bubble;

  logic        rd_st;
  logic        avail;
  logic        outstanding;
  logic [15:0] word;
  logic [15:0] pc_inc;
  logic        unused_stall;

  // A read without done in FETCH/WAIT is already treated
  // as in flight, so imem_stall adds no information.
  assign unused_stall = imem_stall;

  assign rd_st = (state_q == S_FETCH) | (state_q == S_WAIT)
               | (state_q == S_DRAIN);
  assign imem_rd   = rd_st & ~rst;
  assign imem_addr = pc_q;
  assign pc_inc    = pc_q + 16'd2;

  assign avail = (state_q == S_HOLD)
               | (((state_q == S_FETCH) | (state_q == S_WAIT))
                  & imem_done);
  assign word = (state_q == S_HOLD) ? hold_q : imem_data;

  // read still pending after this cycle
  assign outstanding = rd_st & ~imem_done;

  assign instr_id = ifid_q.instr;
  assign pc2_id   = ifid_q.pc2;
  assign valid_id = ifid_q.valid;
  assign halted   = halted_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    halted_d = halted_q;
    ifid_d   = ifid_q;
    bubble   = ifid_q;
    bubble.instr = NOP_INSTR;
    bubble.valid = 1'b0;
    if (redirect) begin
      pc_d     = redirect_pc;
      ifid_d   = bubble;
      halted_d = 1'b0;
      state_d  = outstanding ? S_DRAIN : S_FETCH;
    end else if (stall_id) begin
      unique case (state_q)
        S_FETCH, S_WAIT: begin
          if (imem_done) begin
            hold_d  = imem_data;
            state_d = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_DRAIN: if (imem_done) state_d = S_FETCH;
        default: ;
      endcase
    end else if (avail) begin
      ifid_d.instr = word;
      ifid_d.pc2   = pc_inc;
      ifid_d.valid = 1'b1;
      if (word[15:11] == 5'b00000) begin
        halted_d = 1'b1;
        state_d  = S_HALT;
      end else begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
    end else begin
      ifid_d = bubble;
      unique case (state_q)
        S_FETCH: state_d = S_WAIT;
        S_DRAIN: if (imem_done) state_d = S_FETCH;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      hold_q       <= 16'h0000;
      halted_q     <= 1'b0;
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pc2   <= 16'h0000;
      ifid_q.valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      halted_q <= halted_d;
      ifid_q   <= ifid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + random bench for fetch_stage.
// Reference model tracks pc, held word, drop flag and halt.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_id = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_done = 1'b0;
  logic        imem_stall = 1'b0;
  logic [15:0] instr_id;
  logic [15:0] pc2_id;
  logic        valid_id;
  logic        halted;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .stall_id(stall_id),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_rd(imem_rd),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .imem_done(imem_done),
    .imem_stall(imem_stall),
    .instr_id(instr_id),
    .pc2_id(pc2_id),
    .valid_id(valid_id),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [15:0] mem [256];

  logic [15:0] m_pc, m_hword, m_instr, m_pc2;
  bit          m_drop, m_held, m_halt, m_valid;

  function automatic logic [7:0] idx(input logic [15:0] a);
    return a[8:1];
  endfunction

  function automatic bit m_rd();
    return !m_halt && !m_held;
  endfunction

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_hword = 16'h0000;
    m_instr = 16'h0800; m_pc2 = 16'h0000;
    m_drop = 0; m_held = 0; m_halt = 0; m_valid = 0;
  endtask

  task automatic model_bubble();
    m_instr = 16'h0800;
    m_valid = 0;
  endtask

  task automatic model_step(input bit r, input logic [15:0] rpc,
                            input bit s, input bit dn,
                            input logic [15:0] data);
    bit rd, pending, have;
    logic [15:0] w;
    rd      = m_rd();
    pending = rd && !dn;
    if (r) begin
      m_pc = rpc;
      model_bubble();
      m_halt = 0; m_held = 0;
      m_drop = pending;
    end else begin
      have = m_held || (rd && dn && !m_drop);
      w    = m_held ? m_hword : data;
      if (m_drop && dn) m_drop = 0;
      if (s) begin
        if (have && !m_held) begin
          m_held = 1; m_hword = w;
        end
      end else if (have) begin
        m_instr = w; m_pc2 = m_pc + 16'd2; m_valid = 1;
        m_held = 0;
        if (w[15:11] == 5'b00000) m_halt = 1;
        else m_pc = m_pc + 16'd2;
      end else begin
        model_bubble();
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rd"}, {15'd0, imem_rd}, {15'd0, m_rd()});
    check({tag, ".addr"}, imem_addr, m_pc);
    check({tag, ".instr"}, instr_id, m_instr);
    check({tag, ".valid"}, {15'd0, valid_id}, {15'd0, m_valid});
    check({tag, ".halted"}, {15'd0, halted}, {15'd0, m_halt});
    if (m_valid) check({tag, ".pc2"}, pc2_id, m_pc2);
  endtask

  // called at a negedge; drives, clocks, checks at next negedge
  task automatic step(input bit r, input logic [15:0] rpc,
                      input bit s, input bit dn, input bit st,
                      input string tag);
    bit rd;
    logic [15:0] d;
    rd = m_rd();
    d  = mem[idx(m_pc)];
    redirect    = r;
    redirect_pc = rpc;
    stall_id    = s;
    imem_done   = dn && rd;
    imem_stall  = st && rd;
    imem_data   = d;
    model_step(r, rpc, s, dn && rd, d);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".rd"}, {15'd0, imem_rd}, 16'h0000);
    check({tag, ".addr"}, imem_addr, 16'h0000);
    check({tag, ".instr"}, instr_id, 16'h0800);
    check({tag, ".pc2"}, pc2_id, 16'h0000);
    check({tag, ".valid"}, {15'd0, valid_id}, 16'h0000);
    check({tag, ".halted"}, {15'd0, halted}, 16'h0000);
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 256; i++) mem[i] = 16'h4400;
    mem[0] = 16'h4000; mem[1] = 16'h4001; mem[2] = 16'h4002;
    mem[idx(16'h000E)] = 16'h6e0e;
    mem[idx(16'h0010)] = 16'h5a10;
    mem[idx(16'h0030)] = 16'h0000;
    mem[idx(16'h0040)] = 16'h7040;
    mem[idx(16'h0050)] = 16'h3050;
    mem[idx(16'hFFFE)] = 16'h4abc;

    @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    model_reset();

    // 1: zero-wait stream
    step(0, 0, 0, 1, 0, "t1a");
    check("t1a.i", instr_id, 16'h4000);
    check("t1a.p", pc2_id, 16'h0002);
    step(0, 0, 0, 1, 0, "t1b");
    check("t1b.p", pc2_id, 16'h0004);
    step(0, 0, 0, 1, 0, "t1c");
    check("t1c.i", instr_id, 16'h4002);
    check("t1c.p", pc2_id, 16'h0006);

    // 2: stall with word available at 0x0010
    step(1, 16'h000E, 0, 1, 0, "t2r");
    step(0, 0, 0, 1, 0, "t2e");
    check("t2e.i", instr_id, 16'h6e0e);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 0, "t2s");
      check("t2s.i", instr_id, 16'h6e0e);
      check("t2s.rd", {15'd0, imem_rd}, 16'h0000);
    end
    step(0, 0, 0, 0, 0, "t2u");
    check("t2u.i", instr_id, 16'h5a10);
    check("t2u.p", pc2_id, 16'h0012);

    // 3: redirect beats stall
    step(1, 16'h0100, 1, 1, 0, "t3");
    check("t3.i", instr_id, 16'h0800);
    check("t3.a", imem_addr, 16'h0100);

    // 4: redirect during a multi-cycle read -> drain
    step(1, 16'h0020, 0, 1, 0, "t4r");
    step(0, 0, 0, 0, 1, "t4s1");
    step(1, 16'h0040, 0, 0, 1, "t4s2");
    check("t4s2.a", imem_addr, 16'h0040);
    step(0, 0, 0, 0, 1, "t4s3");
    step(0, 0, 0, 1, 0, "t4d");
    check("t4d.v", {15'd0, valid_id}, 16'h0000);
    step(0, 0, 0, 1, 0, "t4n");
    check("t4n.i", instr_id, 16'h7040);

    // 5: HALT then redirect out
    step(1, 16'h0030, 0, 1, 0, "t5r");
    step(0, 0, 0, 1, 0, "t5h");
    check("t5h.h", {15'd0, halted}, 16'h0001);
    check("t5h.rd", {15'd0, imem_rd}, 16'h0000);
    step(0, 0, 0, 1, 0, "t5i");
    check("t5i.a", imem_addr, 16'h0030);
    step(1, 16'h0050, 0, 0, 0, "t5x");
    check("t5x.h", {15'd0, halted}, 16'h0000);
    step(0, 0, 0, 1, 0, "t5f");
    check("t5f.i", instr_id, 16'h3050);

    // 6: pc wrap, then async reset mid-WAIT
    step(1, 16'hFFFE, 0, 1, 0, "t6r");
    step(0, 0, 0, 1, 0, "t6w");
    check("t6w.p", pc2_id, 16'h0000);
    check("t6w.a", imem_addr, 16'h0000);
    step(0, 0, 0, 0, 1, "t6s");
    #2 rst = 1'b1;
    #1 check_reset("t6rst");
    @(negedge clk);
    rst = 1'b0;
    redirect = 0; stall_id = 0;
    imem_done = 0; imem_stall = 0;
    model_reset();

    // random phase
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if ($urandom_range(11, 0) == 0) w[15:11] = 5'b00000;
      mem[i] = w;
    end
    for (int n = 0; n < 1500; n++) begin
      bit r, s, dn, st;
      r  = ($urandom_range(9, 0) == 0);
      s  = ($urandom_range(3, 0) == 0);
      dn = ($urandom_range(2, 0) != 0);
      st = !dn && ($urandom_range(1, 0) == 1);
      step(r, 16'($urandom), s, dn, st, "rnd");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
